// File: rtl/uart_tx_device_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register addresses,
// control/status bit positions and the serialiser state encoding.
package uart_tx_device_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_EMPTY_BIT    = 0;
  localparam int CON_FULL_BIT     = 1;
  localparam int CON_BUSY_BIT     = 2;
  localparam int CON_IRQ_EN_BIT   = 3;
  localparam int CON_DONE_BIT     = 4;
  localparam int CON_OVERFLOW_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised. The head entry is
// visible combinationally so the serialiser can load it on the same edge it pops.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == COUNT_FULL);
  assign pop_data = mem[rd_ptr_reg];

  // A push while full is still taken when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped UART transmitter: TXD/CON register decode, status flags and
// interrupt, 8N1 serialiser fed from a byte FIFO.
module uart_tx_device
  import uart_tx_device_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] DeviceData,
  input  logic        writeEn,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        irq
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e     state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          irq_en_reg, done_reg, overflow_reg;

  logic          wr_txd, wr_con;
  logic          fifo_pop, fifo_empty, fifo_full;
  logic [7:0]    fifo_data;
  logic          done_set, overflow_set, bit_end;
  logic          unused_data_bits;

  assign wr_txd = writeEn && (Address == UART_TXD_ADDR);
  assign wr_con = writeEn && (Address == UART_CON_ADDR);
  assign unused_data_bits = ^DeviceData[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_txd),
    .push_data (DeviceData[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign overflow_set = wr_txd && fifo_full && !fifo_pop;
  assign bit_end      = (timer_reg == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;
    done_set   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_data;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          timer_next = '0;
          idx_next   = '0;
          state_next = ST_DATA;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_next = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          timer_next = '0;
          done_set   = 1'b1;
          // Chain straight into the next frame when more data is queued.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_data;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_reg   <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_con) begin
        irq_en_reg <= DeviceData[CON_IRQ_EN_BIT];
      end
      if (done_set) begin
        done_reg <= 1'b1;
      end else if (wr_con && DeviceData[CON_DONE_BIT]) begin
        done_reg <= 1'b0;
      end
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end else if (wr_con && DeviceData[CON_OVERFLOW_BIT]) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (Address == UART_CON_ADDR) begin
      ReadData[CON_EMPTY_BIT]    = fifo_empty;
      ReadData[CON_FULL_BIT]     = fifo_full;
      ReadData[CON_BUSY_BIT]     = (state_reg != ST_IDLE);
      ReadData[CON_IRQ_EN_BIT]   = irq_en_reg;
      ReadData[CON_DONE_BIT]     = done_reg;
      ReadData[CON_OVERFLOW_BIT] = overflow_reg;
    end
  end

  assign tx  = tx_reg;
  assign irq = done_reg && irq_en_reg;

endmodule

// File: tb/tb_uart_tx_device.sv
// Directed bench for uart_tx_device: stimulus queues expected frames, a line
// monitor decodes tx and compares each frame against the queue.
module tb_uart_tx_device;
  import uart_tx_device_pkg::*;

  localparam int CPB = 4;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] DeviceData;
  logic        writeEn;
  logic [31:0] ReadData;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  typedef struct {
    logic [7:0] data;
    int         gap;    // expected idle cycles before the frame, -1 = don't care
    bit         abort;  // frame expected to be cut short by reset
  } exp_t;

  exp_t sb_q[$];

  uart_tx_device #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .DeviceData (DeviceData),
    .writeEn    (writeEn),
    .ReadData   (ReadData),
    .tx         (tx),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    Address = a;
    #1;
    chk(name, ReadData, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address    = a;
    DeviceData = d;
    writeEn    = 1'b1;
  endtask

  task automatic wr_end();
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int gap, input bit abort);
    exp_t e;
    e.data  = d;
    e.gap   = gap;
    e.abort = abort;
    sb_q.push_back(e);
  endtask

  // Line monitor: samples tx on every falling edge and decodes 10-bit frames.
  initial begin
    int         idle_cnt;
    exp_t       e;
    logic [9:0] pat;
    logic [9:0] got;
    bit         bad;
    bit         aborted;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset || tx) begin
        idle_cnt++;
        continue;
      end
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got start bit expected idle line at %0t", $time);
        repeat (10 * CPB - 1) @(negedge clk);
        idle_cnt = 0;
        continue;
      end
      e       = sb_q.pop_front();
      pat     = {1'b1, e.data, 1'b0};
      got     = '0;
      bad     = 1'b0;
      aborted = 1'b0;
      for (int s = 0; s < 10 * CPB; s++) begin
        if (s > 0) @(negedge clk);
        if (!reset) begin
          aborted = 1'b1;
          break;
        end
        if (tx !== pat[s / CPB]) bad = 1'b1;
        if ((s % CPB) == CPB / 2) got[s / CPB] = tx;
      end
      frames++;
      if (aborted) begin
        checks++;
        if (!e.abort || tx !== 1'b1) begin
          errors++;
          $display("FAIL frame_abort: got tx=%0b abort_expected=%0b expected tx=1 abort_expected=1",
                   tx, e.abort);
        end else begin
          $display("frame %0d: 0x%02h aborted by reset, tx=%0b", frames, e.data, tx);
        end
      end else begin
        checks++;
        if (e.abort || bad) begin
          errors++;
          $display("FAIL frame_data: got 0x%03h expected 0x%03h (abort_expected=%0b)",
                   got, pat, e.abort);
        end else begin
          $display("frame %0d: 0x%02h gap=%0d", frames, e.data, idle_cnt);
        end
        if (e.gap >= 0) begin
          checks++;
          if (idle_cnt != e.gap) begin
            errors++;
            $display("FAIL frame_gap: got %0d idle cycles expected %0d", idle_cnt, e.gap);
          end
        end
      end
      idle_cnt = 0;
    end
  end

  initial begin
    reset      = 1'b0;
    writeEn    = 1'b0;
    Address    = '0;
    DeviceData = '0;

    // Reset state
    #12;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd(UART_CON_ADDR, 32'h01, "reset_con");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0xA5 with latency check
    expect_frame(8'hA5, -1, 1'b0);
    wr(UART_TXD_ADDR, 32'h0000_00A5);
    wr_end();
    chk("latency_pre", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("latency_start", {31'd0, tx}, 32'd0);
    repeat (41) @(negedge clk);
    rd(UART_CON_ADDR, 32'h11, "a5_con_done");
    wr(UART_CON_ADDR, 32'h10);
    wr_end();
    rd(UART_CON_ADDR, 32'h01, "done_clear");

    // Five back-to-back pushes from idle: contiguous frames, no overflow
    expect_frame(8'h01, -1, 1'b0);
    for (int i = 2; i <= 5; i++) expect_frame(8'(i), 0, 1'b0);
    for (int i = 1; i <= 5; i++) wr(UART_TXD_ADDR, 32'(i));
    wr_end();
    rd(UART_CON_ADDR, 32'h06, "five_full_busy");
    repeat (205) @(negedge clk);
    rd(UART_CON_ADDR, 32'h11, "five_con_done");
    wr(UART_CON_ADDR, 32'h10);
    wr_end();

    // Six pushes: sixth dropped, overflow set then cleared
    expect_frame(8'h11, -1, 1'b0);
    for (int i = 2; i <= 5; i++) expect_frame(8'(8'h10 + i), 0, 1'b0);
    for (int i = 1; i <= 6; i++) wr(UART_TXD_ADDR, 32'(8'h10 + i));
    wr_end();
    rd(UART_CON_ADDR, 32'h26, "six_overflow");
    wr(UART_CON_ADDR, 32'h20);
    wr_end();
    rd(UART_CON_ADDR, 32'h06, "overflow_clear");
    repeat (205) @(negedge clk);
    rd(UART_CON_ADDR, 32'h11, "six_con_done");
    wr(UART_CON_ADDR, 32'h10);
    wr_end();

    // Interrupt on frame completion
    wr(UART_CON_ADDR, 32'h08);
    wr_end();
    rd(UART_CON_ADDR, 32'h09, "irq_en_set");
    expect_frame(8'h55, -1, 1'b0);
    wr(UART_TXD_ADDR, 32'h55);
    wr_end();
    repeat (40) @(negedge clk);
    chk("irq_before_stop_end", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_after_stop_end", {31'd0, irq}, 32'd1);
    wr(UART_CON_ADDR, 32'h18);
    wr_end();
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd(UART_CON_ADDR, 32'h09, "irq_con_after_clear");

    // Push at full on the same edge as the STOP->START pop is accepted
    expect_frame(8'h21, -1, 1'b0);
    for (int i = 2; i <= 6; i++) expect_frame(8'(8'h20 + i), 0, 1'b0);
    for (int i = 1; i <= 5; i++) wr(UART_TXD_ADDR, 32'(8'h20 + i));
    wr_end();
    repeat (35) @(negedge clk);
    wr(UART_TXD_ADDR, 32'h26);
    wr_end();
    rd(UART_CON_ADDR, 32'h1E, "push_pop_no_overflow");
    repeat (210) @(negedge clk);
    rd(UART_CON_ADDR, 32'h19, "push_pop_con_done");
    chk("push_pop_irq", {31'd0, irq}, 32'd1);
    wr(UART_CON_ADDR, 32'h10);
    wr_end();
    rd(UART_CON_ADDR, 32'h01, "con_idle");

    // Reset mid-frame during DATA bit 3 of 0xFF
    expect_frame(8'hFF, -1, 1'b1);
    wr(UART_TXD_ADDR, 32'hFF);
    wr_end();
    repeat (18) @(negedge clk);
    rd(UART_CON_ADDR, 32'h05, "busy_before_reset");
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_irq", {31'd0, irq}, 32'd0);
    rd(UART_CON_ADDR, 32'h01, "reset_mid_con");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_resume_tx", {31'd0, tx}, 32'd1);
    rd(UART_CON_ADDR, 32'h01, "no_resume_con");

    // Unmapped addresses
    rd(32'h4000_0024, 32'h0, "unmapped_read");
    wr(32'h4000_001C, 32'h41);
    wr_end();
    rd(32'h4000_001C, 32'h0, "unmapped_read_1c");
    repeat (60) @(negedge clk);
    rd(UART_CON_ADDR, 32'h01, "unmapped_no_effect");

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
